aes_inv_subshift_seq: RTL



---
 rtl/aes_pkg.sv | 41 ++++
 rtl/inv_sbox_lane.sv | 11 +
 rtl/aes_inv_subshift_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-round definitions: inverse S-box table, InvShiftRows byte
// routing helper, sequencer state encoding and block width.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte i = r + 4c takes source r + 4*((c - r) mod 4); the 2-bit subtract wraps mod 4.
  function automatic logic [3:0] inv_shift_src(input logic [3:0] i);
    logic [1:0] r;
    logic [1:0] c;
    r = i[1:0];
    c = i[3:2];
    return {2'(c - r), r};
  endfunction

endpackage

// File: rtl/inv_sbox_lane.sv
// One combinational AES inverse S-box lookup lane.
module inv_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/aes_inv_subshift_seq.sv
// Sequential InvShiftRows + InvSubBytes, LANES bytes per cycle, valid/ready in and out.
// Define AES_INV_ADDKEY_EN to add an rkey port and fuse AddRoundKey into each lane.
module aes_inv_subshift_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
`ifdef AES_INV_ADDKEY_EN
  input  logic [AES_BLK_W-1:0] rkey,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy
);

  localparam int unsigned NCYC  = 16 / LANES;
  localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_inv_subshift_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [AES_BLK_W-1:0] blk_q;
  logic [AES_BLK_W-1:0] out_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;
`ifdef AES_INV_ADDKEY_EN
  logic [AES_BLK_W-1:0] key_q;
`endif

  logic [3:0] lane_idx [LANES];
  logic [7:0] lane_val [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [3:0] src;
    logic [7:0] sub;

    assign lane_idx[j] = 4'(32'(cnt_q) * LANES + 32'(j));
    assign src         = inv_shift_src(lane_idx[j]);

    // Byte k sits at bit 8*(15-k); ~k is 15-k for a 4-bit index.
    inv_sbox_lane u_sbox (
      .byte_i (blk_q[{~src, 3'b000} +: 8]),
      .byte_o (sub)
    );

`ifdef AES_INV_ADDKEY_EN
    assign lane_val[j] = sub ^ key_q[{~lane_idx[j], 3'b000} +: 8];
`else
    assign lane_val[j] = sub;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_INV_ADDKEY_EN
      key_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            blk_q      <= in_data;
`ifdef AES_INV_ADDKEY_EN
            key_q      <= rkey;
`endif
            cnt_q      <= '0;
            state_q    <= ST_BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_BUSY: begin
          for (int unsigned j = 0; j < LANES; j++) begin
            out_q[{~lane_idx[j], 3'b000} +: 8] <= lane_val[j];
          end
          if (cnt_q == CNT_W'(NCYC - 1)) begin
            cnt_q       <= '0;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;

endmodule
